eth_decap: RTL and testbench

- Receive-side counterpart of the TLP encapsulation path.
- Accepts 64-bit AXI-Stream Ethernet frames from the 10G MAC RX port (clk156 domain).
- Filters frames on destination MAC and EtherType, strips the header, and decodes each 16-byte payload record back into one 81-bit TLP-beat word.
- Writes the decoded words into an eth2pcie FIFO through a wr_en/din/full interface, feeding the PCIe-side replay logic.

---
 rtl/eth_decap.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_eth_decap.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_decap.sv
// ---------------------------------------------------------------------------
// eth_decap
//
// Receive-side Ethernet decapsulator. It takes 64-bit AXI-Stream frames from
// the 10G MAC RX port and accepts only frames whose destination MAC is
// LOCAL_MAC (or broadcast, when ACCEPT_BCAST is set) and whose EtherType is
// ETHERTYPE. It strips the two header beats and turns every following pair
// of beats back into one 81-bit TLP-beat word. The decoded words go through a
// single-entry skid register into the eth2pcie FIFO.
//
// Record encoding (two beats per record):
//   word A beat : tdata -> din[63:0]
//   word B beat : byte 0 -> din[71:64] (tkeep)
//                 byte 1 bit 0 -> din[72] (tlast)
//                 byte 2 -> din[80:73] (tuser)
//
// Ports:
//   clk156            core clock (156.25 MHz MAC domain)
//   sys_rst_n         asynchronous active-low reset
//   s_axis_rx_tvalid  MAC RX beat valid (no back-pressure is possible)
//   s_axis_rx_tdata   beat data, wire byte n on [8n+7:8n]
//   s_axis_rx_tkeep   byte enables
//   s_axis_rx_tlast   last beat of frame
//   s_axis_rx_tuser   frame good, meaningful on the tlast beat
//   wr_en             FIFO write strobe
//   din               decoded word {tuser[7:0], tlast, tkeep[7:0], tdata[63:0]}
//   full              FIFO full
//   frame_err         one-cycle pulse for each bad or filtered frame
//   stat_ok/filt/bad/ovf  32-bit statistics counters
//
// Build option:
//   ETH_DECAP_STATS_EN  when defined, the four stat_* outputs are saturating
//                       counters; otherwise they are tied to zero and no
//                       counter logic exists.
// ---------------------------------------------------------------------------
module eth_decap #(
    parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE    = 16'h88B5,
    parameter bit          ACCEPT_BCAST = 1'b1
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        s_axis_rx_tvalid,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    output logic        wr_en,
    output logic [80:0] din,
    input  logic        full,
    output logic        frame_err,
    output logic [31:0] stat_ok,
    output logic [31:0] stat_filt,
    output logic [31:0] stat_bad,
    output logic [31:0] stat_ovf
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        RECA,
        RECB,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] dstMac_q, dstMac_d;
    logic [63:0] wordA_q, wordA_d;
    logic        frameBad_q, frameBad_d;
    logic        frameFilt_q, frameFilt_d;
    logic        pendValid_q, pendValid_d;
    logic [80:0] pendData_q, pendData_d;
    logic        frameErr_q, frameErr_d;

    logic        dstHit;
    logic        typeHit;
    logic        keepOk;
    logic        recValid;
    logic [80:0] recData;
    logic        ovfEvent;
    logic        classOk;
    logic        classBad;
    logic        classFilt;
    logic        unusedKeep;

    // Only the low three byte enables decide whether a word-B beat carries
    // the tkeep/tlast/tuser bytes; the upper enables carry no information.
    assign unusedKeep = ^s_axis_rx_tkeep[7:3];
    assign keepOk     = (s_axis_rx_tkeep[2:0] == 3'b111);

    // Destination MAC is compared in wire order: byte 0 on the wire is the
    // most significant byte of LOCAL_MAC.
    assign dstHit  = (dstMac_q == LOCAL_MAC) ||
                     (ACCEPT_BCAST && (dstMac_q == 48'hFFFF_FFFF_FFFF));
    assign typeHit = ({s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]} == ETHERTYPE);

    assign recData = {s_axis_rx_tdata[23:16], s_axis_rx_tdata[8],
                      s_axis_rx_tdata[7:0], wordA_q};

    // Frame parser. Every transition and every classification happens only
    // on a valid beat; an idle cycle leaves all parser state untouched.
    always_comb begin
        state_d     = state_q;
        dstMac_d    = dstMac_q;
        wordA_d     = wordA_q;
        frameBad_d  = frameBad_q;
        frameFilt_d = frameFilt_q;
        recValid    = 1'b0;
        ovfEvent    = 1'b0;
        classOk     = 1'b0;
        classBad    = 1'b0;
        classFilt   = 1'b0;

        if (s_axis_rx_tvalid) begin
            case (state_q)
                HDR0: begin
                    dstMac_d    = {s_axis_rx_tdata[7:0],   s_axis_rx_tdata[15:8],
                                   s_axis_rx_tdata[23:16], s_axis_rx_tdata[31:24],
                                   s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
                    frameBad_d  = 1'b0;
                    frameFilt_d = 1'b0;
                    if (s_axis_rx_tlast) begin
                        classBad = 1'b1;
                        state_d  = HDR0;
                    end else begin
                        state_d  = HDR1;
                    end
                end

                HDR1: begin
                    if (!(dstHit && typeHit)) begin
                        if (s_axis_rx_tlast) begin
                            classFilt = 1'b1;
                            state_d   = HDR0;
                        end else begin
                            frameFilt_d = 1'b1;
                            state_d     = DROP;
                        end
                    end else if (s_axis_rx_tlast) begin
                        // Header-only frame: nothing to decode, only classify.
                        if (s_axis_rx_tuser) begin
                            classOk  = 1'b1;
                        end else begin
                            classBad = 1'b1;
                        end
                        state_d = HDR0;
                    end else begin
                        state_d = RECA;
                    end
                end

                RECA: begin
                    wordA_d = s_axis_rx_tdata;
                    if (s_axis_rx_tlast) begin
                        classBad = 1'b1;
                        state_d  = HDR0;
                    end else begin
                        state_d  = RECB;
                    end
                end

                RECB: begin
                    // A complete record either enters the skid register or,
                    // when the skid entry is stuck behind a full FIFO, is lost
                    // and poisons the rest of the frame.
                    if (keepOk) begin
                        if (pendValid_q && full) begin
                            ovfEvent   = 1'b1;
                            frameBad_d = 1'b1;
                        end else begin
                            recValid   = 1'b1;
                        end
                    end else begin
                        frameBad_d = 1'b1;
                    end

                    if (s_axis_rx_tlast) begin
                        if (frameBad_d || !s_axis_rx_tuser) begin
                            classBad = 1'b1;
                        end else begin
                            classOk  = 1'b1;
                        end
                        state_d = HDR0;
                    end else if (ovfEvent) begin
                        state_d = DROP;
                    end else begin
                        state_d = RECA;
                    end
                end

                DROP: begin
                    // DROP is entered either by a filter miss or an overflow;
                    // the filter flag tells the two apart at frame end.
                    if (s_axis_rx_tlast) begin
                        if (frameFilt_q) begin
                            classFilt = 1'b1;
                        end else begin
                            classBad  = 1'b1;
                        end
                        state_d = HDR0;
                    end
                end

                default: begin
                    state_d = HDR0;
                end
            endcase
        end
    end

    // Skid entry: a new record always wins the register. When the old entry
    // can drain in the same cycle (pending and not full) it is written by
    // wr_en while the new one is loaded, so nothing is lost.
    always_comb begin
        pendValid_d = pendValid_q;
        pendData_d  = pendData_q;
        if (recValid) begin
            pendValid_d = 1'b1;
            pendData_d  = recData;
        end else if (wr_en) begin
            pendValid_d = 1'b0;
        end
    end

    assign frameErr_d = classBad | classFilt;

    // State registers for the parser, the skid entry and the error pulse.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= HDR0;
            dstMac_q    <= '0;
            wordA_q     <= '0;
            frameBad_q  <= 1'b0;
            frameFilt_q <= 1'b0;
            pendValid_q <= 1'b0;
            pendData_q  <= '0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dstMac_q    <= dstMac_d;
            wordA_q     <= wordA_d;
            frameBad_q  <= frameBad_d;
            frameFilt_q <= frameFilt_d;
            pendValid_q <= pendValid_d;
            pendData_q  <= pendData_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign wr_en     = pendValid_q & ~full;
    assign din       = pendData_q;
    assign frame_err = frameErr_q;

`ifdef ETH_DECAP_STATS_EN
    logic [31:0] statOk_q;
    logic [31:0] statFilt_q;
    logic [31:0] statBad_q;
    logic [31:0] statOvf_q;

    // Saturating statistics: each counter sticks at all-ones instead of
    // wrapping, so a long-running link never reports a misleading small count.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            statOk_q   <= '0;
            statFilt_q <= '0;
            statBad_q  <= '0;
            statOvf_q  <= '0;
        end else begin
            if (classOk && (statOk_q != 32'hFFFF_FFFF)) begin
                statOk_q <= statOk_q + 32'd1;
            end
            if (classFilt && (statFilt_q != 32'hFFFF_FFFF)) begin
                statFilt_q <= statFilt_q + 32'd1;
            end
            if (classBad && (statBad_q != 32'hFFFF_FFFF)) begin
                statBad_q <= statBad_q + 32'd1;
            end
            if (ovfEvent && (statOvf_q != 32'hFFFF_FFFF)) begin
                statOvf_q <= statOvf_q + 32'd1;
            end
        end
    end

    assign stat_ok   = statOk_q;
    assign stat_filt = statFilt_q;
    assign stat_bad  = statBad_q;
    assign stat_ovf  = statOvf_q;
`else
    logic unusedClass;

    assign unusedClass = classOk;
    assign stat_ok     = '0;
    assign stat_filt   = '0;
    assign stat_bad    = '0;
    assign stat_ovf    = '0;
`endif

endmodule

// File: tb/tb_eth_decap.sv
// ---------------------------------------------------------------------------
// tb_eth_decap
//
// Self-checking bench for eth_decap. Frames are built from a description
// (destination, EtherType, record count, how the frame ends) with random
// payload, idle gaps and FIFO-full patterns. A frame-level reference model
// tracks the position of each beat inside its frame and predicts, for every
// cycle, wr_en, din, frame_err and the statistics outputs.
// ---------------------------------------------------------------------------
module tb_eth_decap;

   localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] ETYPE_OK  = 16'h88B5;

   logic        clk156;
   logic        sys_rst_n;
   logic        s_axis_rx_tvalid;
   logic [63:0] s_axis_rx_tdata;
   logic [7:0]  s_axis_rx_tkeep;
   logic        s_axis_rx_tlast;
   logic        s_axis_rx_tuser;
   logic        wr_en;
   logic [80:0] din;
   logic        full;
   logic        frame_err;
   logic [31:0] stat_ok;
   logic [31:0] stat_filt;
   logic [31:0] stat_bad;
   logic [31:0] stat_ovf;

   eth_decap dut (
      .clk156           (clk156),
      .sys_rst_n        (sys_rst_n),
      .s_axis_rx_tvalid (s_axis_rx_tvalid),
      .s_axis_rx_tdata  (s_axis_rx_tdata),
      .s_axis_rx_tkeep  (s_axis_rx_tkeep),
      .s_axis_rx_tlast  (s_axis_rx_tlast),
      .s_axis_rx_tuser  (s_axis_rx_tuser),
      .wr_en            (wr_en),
      .din              (din),
      .full             (full),
      .frame_err        (frame_err),
      .stat_ok          (stat_ok),
      .stat_filt        (stat_filt),
      .stat_bad         (stat_bad),
      .stat_ovf         (stat_ovf)
   );

   initial clk156 = 1'b0;
   always #5 clk156 = ~clk156;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      bit          last;
      bit          user;
   } beat_t;

   beat_t frameQ[$];

   int vectors;
   int miscompares;

   // Reference model state: beat position inside the frame, frame flags,
   // the single pending FIFO word and the predicted registered outputs.
   int          mIdx;
   bit          mDrop;
   bit          mBad;
   bit          mFilt;
   logic [47:0] mDst;
   logic [63:0] mWordA;
   bit          mPendV;
   logic [80:0] mPendD;
   bit          mFrameErr;
   int unsigned mOk;
   int unsigned mFiltCnt;
   int unsigned mBadCnt;
   int unsigned mOvf;

   // Compare one observed value with its expectation and log any difference.
   task automatic checkOutput(input string tag, input logic [80:0] observed,
                              input logic [80:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [31:0] expStat(input int unsigned cnt);
`ifdef ETH_DECAP_STATS_EN
      return cnt;
`else
      return (cnt == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   function automatic void resetModel();
      mIdx      = 0;
      mDrop     = 0;
      mBad      = 0;
      mFilt     = 0;
      mDst      = '0;
      mWordA    = '0;
      mPendV    = 0;
      mPendD    = '0;
      mFrameErr = 0;
      mOk       = 0;
      mFiltCnt  = 0;
      mBadCnt   = 0;
      mOvf      = 0;
   endfunction

   // 0 = ok, 1 = filtered, 2 = bad
   function automatic void classify(input int kind);
      mFrameErr = (kind != 0);
      if (kind == 0) mOk++;
      else if (kind == 1) mFiltCnt++;
      else mBadCnt++;
   endfunction

   // Advance the model across one rising edge with the given inputs.
   function automatic void modelStep(input bit v, input logic [63:0] d, input logic [7:0] k,
                                     input bit l, input bit u, input bit f);
      bit          writeNow;
      bit          loadNew;
      bit          match;
      logic [80:0] rec;
      writeNow  = mPendV && !f;
      loadNew   = 0;
      rec       = '0;
      mFrameErr = 0;
      if (v) begin
         if (mIdx == 0) begin
            for (int i = 0; i < 6; i++) mDst[47-8*i -: 8] = d[8*i +: 8];
            mBad  = 0;
            mFilt = 0;
            mDrop = 0;
            if (l) classify(2);
            else mIdx = 1;
         end else if (mIdx == 1) begin
            match = ((mDst == LOCAL_MAC) || (mDst == BCAST_MAC)) &&
                    ({d[39:32], d[47:40]} == ETYPE_OK);
            if (!match) begin
               if (l) begin
                  classify(1);
                  mIdx = 0;
               end else begin
                  mDrop = 1;
                  mFilt = 1;
                  mIdx  = 2;
               end
            end else if (l) begin
               classify(u ? 0 : 2);
               mIdx = 0;
            end else begin
               mIdx = 2;
            end
         end else if (mDrop) begin
            if (l) begin
               classify(mFilt ? 1 : 2);
               mIdx = 0;
            end
         end else if ((mIdx % 2) == 0) begin
            mWordA = d;
            if (l) begin
               classify(2);
               mIdx = 0;
            end else begin
               mIdx++;
            end
         end else begin
            if (k[2:0] == 3'b111) begin
               rec = {d[23:16], d[8], d[7:0], mWordA};
               if (mPendV && f) begin
                  mOvf++;
                  mBad  = 1;
                  mDrop = 1;
               end else begin
                  loadNew = 1;
               end
            end else begin
               mBad = 1;
            end
            if (l) begin
               classify((mBad || !u) ? 2 : 0);
               mIdx = 0;
            end else begin
               mIdx++;
            end
         end
      end
      if (loadNew) begin
         mPendV = 1;
         mPendD = rec;
      end else if (writeNow) begin
         mPendV = 0;
      end
   endfunction

   // Drive one cycle of inputs, check the outputs it produces, then step the
   // model across the following rising edge.
   task automatic applyStimulus(input bit v, input logic [63:0] d, input logic [7:0] k,
                                input bit l, input bit u, input bit f);
      @(negedge clk156);
      s_axis_rx_tvalid = v;
      s_axis_rx_tdata  = d;
      s_axis_rx_tkeep  = k;
      s_axis_rx_tlast  = l;
      s_axis_rx_tuser  = u;
      full             = f;
      #1;
      checkOutput("wr_en", wr_en, mPendV && !f);
      checkOutput("din", din, mPendD);
      checkOutput("frame_err", frame_err, mFrameErr);
      checkOutput("stat_ok", stat_ok, expStat(mOk));
      checkOutput("stat_filt", stat_filt, expStat(mFiltCnt));
      checkOutput("stat_bad", stat_bad, expStat(mBadCnt));
      checkOutput("stat_ovf", stat_ovf, expStat(mOvf));
      modelStep(v, d, k, l, u, f);
      @(posedge clk156);
   endtask

   function automatic bit fullFor(input int mode);
      if (mode == 0) return 1'b0;
      if (mode == 2) return 1'b1;
      return ($urandom_range(0, 2) == 0);
   endfunction

   task automatic idle(input int n, input int fullMode);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, {$urandom, $urandom}, 8'($urandom), 1'($urandom),
                       1'($urandom), fullFor(fullMode));
   endtask

   // nRec < 0 builds a one-beat runt; nRec == 0 a header-only frame.
   task automatic buildFrame(input logic [47:0] dst, input logic [15:0] etype, input int nRec,
                             input bit endOnA, input bit userEnd, input int badKeepIdx);
      beat_t b;
      frameQ.delete();
      b.data = {$urandom, $urandom};
      for (int i = 0; i < 6; i++) b.data[8*i +: 8] = dst[47-8*i -: 8];
      b.keep = 8'hFF;
      b.last = 0;
      b.user = 1'($urandom);
      frameQ.push_back(b);
      if (nRec >= 0) begin
         b.data        = {$urandom, $urandom};
         b.data[39:32] = etype[15:8];
         b.data[47:40] = etype[7:0];
         frameQ.push_back(b);
         for (int r = 0; r < nRec; r++) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'hFF;
            frameQ.push_back(b);
            b.data = {$urandom, $urandom};
            if (r == badKeepIdx) b.keep = {5'($urandom), 3'($urandom_range(0, 6))};
            else b.keep = {5'($urandom), 3'b111};
            frameQ.push_back(b);
         end
         if (endOnA) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'hFF;
            frameQ.push_back(b);
         end
      end
      b      = frameQ.pop_back();
      b.last = 1;
      b.user = userEnd;
      frameQ.push_back(b);
   endtask

   task automatic sendBeats(input int fullMode, input bit gaps, input int count);
      for (int i = 0; i < count && i < frameQ.size(); i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 2), fullMode);
         applyStimulus(1'b1, frameQ[i].data, frameQ[i].keep, frameQ[i].last,
                       frameQ[i].user, fullFor(fullMode));
      end
   endtask

   task automatic sendFrame(input logic [47:0] dst, input logic [15:0] etype, input int nRec,
                            input bit endOnA, input bit userEnd, input int badKeepIdx,
                            input int fullMode, input bit gaps);
      buildFrame(dst, etype, nRec, endOnA, userEnd, badKeepIdx);
      sendBeats(fullMode, gaps, frameQ.size());
   endtask

   // Assert reset asynchronously between clock edges and check that the
   // outputs clear without waiting for a clock.
   task automatic pulseReset();
      @(negedge clk156);
      #2;
      s_axis_rx_tvalid = 1'b0;
      full             = 1'b0;
      sys_rst_n        = 1'b0;
      #1;
      resetModel();
      checkOutput("rst_wr_en", wr_en, 1'b0);
      checkOutput("rst_din", din, 81'd0);
      checkOutput("rst_frame_err", frame_err, 1'b0);
      checkOutput("rst_stat_ok", stat_ok, 32'd0);
      checkOutput("rst_stat_bad", stat_bad, 32'd0);
      checkOutput("rst_stat_ovf", stat_ovf, 32'd0);
      @(posedge clk156);
      @(negedge clk156);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [47:0] dst;
      logic [15:0] etype;
      int          sel;
      int          nRec;

      vectors          = 0;
      miscompares      = 0;
      sys_rst_n        = 1'b0;
      s_axis_rx_tvalid = 1'b0;
      s_axis_rx_tdata  = '0;
      s_axis_rx_tkeep  = '0;
      s_axis_rx_tlast  = 1'b0;
      s_axis_rx_tuser  = 1'b0;
      full             = 1'b0;
      resetModel();

      // Initial reset.
      pulseReset();
      idle(2, 0);

      // Matched frame with three records, FIFO always ready.
      sendFrame(LOCAL_MAC, ETYPE_OK, 3, 0, 1, -1, 0, 0);
      idle(2, 0);

      // Filtered IPv4 frame followed back-to-back by a matched frame.
      sendFrame(LOCAL_MAC, 16'h0800, 1, 0, 1, -1, 0, 0);
      sendFrame(LOCAL_MAC, ETYPE_OK, 2, 0, 1, -1, 0, 0);
      idle(2, 0);

      // FIFO full across the whole frame: first record held, second dropped.
      sendFrame(LOCAL_MAC, ETYPE_OK, 3, 0, 1, -1, 2, 0);
      idle(3, 0);

      // Frame ending on word A, then a frame with tuser low at its end.
      sendFrame(LOCAL_MAC, ETYPE_OK, 1, 1, 1, -1, 0, 0);
      sendFrame(LOCAL_MAC, ETYPE_OK, 2, 0, 0, -1, 0, 0);
      idle(2, 0);

      // Runt, header-only, broadcast and partial-record frames.
      sendFrame(LOCAL_MAC, ETYPE_OK, -1, 0, 1, -1, 0, 0);
      sendFrame(LOCAL_MAC, ETYPE_OK, 0, 0, 1, -1, 0, 0);
      sendFrame(BCAST_MAC, ETYPE_OK, 2, 0, 1, -1, 0, 0);
      sendFrame(LOCAL_MAC, ETYPE_OK, 3, 0, 1, 1, 0, 0);
      sendFrame(48'h02_00_00_00_00_02, ETYPE_OK, 1, 0, 1, -1, 0, 0);
      idle(2, 0);

      // Reset in the middle of a frame with a record waiting behind full.
      buildFrame(LOCAL_MAC, ETYPE_OK, 3, 0, 1, -1);
      sendBeats(2, 0, 5);
      pulseReset();
      sendFrame(LOCAL_MAC, ETYPE_OK, 2, 0, 1, -1, 0, 0);
      idle(2, 0);

      // Randomized frames with idle gaps and random FIFO back-pressure.
      for (int n = 0; n < 120; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7) dst = LOCAL_MAC;
         else if (sel == 7) dst = BCAST_MAC;
         else if (sel == 8) dst = LOCAL_MAC ^ (48'd1 << $urandom_range(0, 47));
         else dst = {$urandom, 16'($urandom)};
         etype = ($urandom_range(0, 5) == 0) ? 16'($urandom) : ETYPE_OK;
         nRec  = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 4);
         sendFrame(dst, etype, nRec, ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) != 0),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1,
                   ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1),
                   1'($urandom));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), $urandom_range(0, 1));
      end
      idle(4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
